// File: rtl/imm_alu_sequencer.sv
// rtl/imm_alu_sequencer.sv - hardwired fetch/execute sequencer for immediate-ALU instructions
// Drives T0-T5 datapath strobes with a memory-ready wait loop, wait timeout and illegal-op trap.
module imm_alu_sequencer #(
  parameter int OPCODE_WIDTH   = 5,
  parameter int ALU_CODE_WIDTH = 5,
  parameter logic [ALU_CODE_WIDTH-1:0] ALU_INC_PC     = 5'b11111,
  parameter logic [OPCODE_WIDTH-1:0]   OP_ADDI        = 5'b01100,
  parameter logic [OPCODE_WIDTH-1:0]   OP_ANDI        = 5'b01101,
  parameter logic [OPCODE_WIDTH-1:0]   OP_ORI         = 5'b01110,
  parameter logic [OPCODE_WIDTH-1:0]   OP_EXTRA       = 5'b01111,
  parameter logic [ALU_CODE_WIDTH-1:0] EXTRA_ALU_CODE = 5'b00100,
  parameter int MAX_WAIT = 15
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      run,
  input  logic [OPCODE_WIDTH-1:0]   ir_opcode,
  input  logic                      mem_ready,
  output logic                      PCOut,
  output logic                      MARIn,
  output logic                      ZIn,
  output logic                      ZLoOut,
  output logic                      PCIn,
  output logic                      memread,
  output logic                      MDRIn,
  output logic                      MDROut,
  output logic                      IRIn,
  output logic                      Gra,
  output logic                      Grb,
  output logic                      RIn,
  output logic                      ROut,
  output logic                      YIn,
  output logic                      COut,
  output logic [ALU_CODE_WIDTH-1:0] ALUCode,
  output logic                      busy,
  output logic                      instr_done,
  output logic                      illegal_op,
  output logic                      mem_timeout
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  localparam logic [ALU_CODE_WIDTH-1:0] ALU_ADDI = ALU_CODE_WIDTH'(5'b00011);
  localparam logic [ALU_CODE_WIDTH-1:0] ALU_ANDI = ALU_CODE_WIDTH'(5'b00101);
  localparam logic [ALU_CODE_WIDTH-1:0] ALU_ORI  = ALU_CODE_WIDTH'(5'b00110);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_TRAP_ILL, S_TRAP_TMO
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           wait_q, wait_d;
  logic [OPCODE_WIDTH-1:0] op_q, op_d;
  logic                    op_legal;
  logic [ALU_CODE_WIDTH-1:0] op_alu;

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
    end
  end

  assign op_legal = (ir_opcode == OP_ADDI) || (ir_opcode == OP_ANDI) ||
                    (ir_opcode == OP_ORI)  || (ir_opcode == OP_EXTRA);

  always_comb begin
    op_alu = '0;
    if      (op_q == OP_ADDI)  op_alu = ALU_ADDI;
    else if (op_q == OP_ANDI)  op_alu = ALU_ANDI;
    else if (op_q == OP_ORI)   op_alu = ALU_ORI;
    else if (op_q == OP_EXTRA) op_alu = EXTRA_ALU_CODE;
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    op_d        = op_q;
    PCOut       = 1'b0;
    MARIn       = 1'b0;
    ZIn         = 1'b0;
    ZLoOut      = 1'b0;
    PCIn        = 1'b0;
    memread     = 1'b0;
    MDRIn       = 1'b0;
    MDROut      = 1'b0;
    IRIn        = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    RIn         = 1'b0;
    ROut        = 1'b0;
    YIn         = 1'b0;
    COut        = 1'b0;
    ALUCode     = '0;
    busy        = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        busy    = 1'b1;
        PCOut   = 1'b1;
        MARIn   = 1'b1;
        ZIn     = 1'b1;
        ALUCode = ALU_INC_PC;
        wait_d  = '0;
        state_d = S_T1;
      end
      S_T1: begin
        busy    = 1'b1;
        memread = 1'b1;
        MDRIn   = 1'b1;
        // Ready wins over timeout even on the last permitted wait cycle.
        if (mem_ready) begin
          ZLoOut  = 1'b1;
          PCIn    = 1'b1;
          wait_d  = '0;
          state_d = S_T2;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP_TMO;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_T2: begin
        busy    = 1'b1;
        MDROut  = 1'b1;
        IRIn    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        busy    = 1'b1;
        Grb     = 1'b1;
        ROut    = 1'b1;
        YIn     = 1'b1;
        op_d    = ir_opcode;
        state_d = op_legal ? S_T4 : S_TRAP_ILL;
      end
      S_T4: begin
        busy    = 1'b1;
        COut    = 1'b1;
        ZIn     = 1'b1;
        ALUCode = op_alu;
        state_d = S_T5;
      end
      S_T5: begin
        busy       = 1'b1;
        ZLoOut     = 1'b1;
        Gra        = 1'b1;
        RIn        = 1'b1;
        instr_done = 1'b1;
        state_d    = run ? S_T0 : S_IDLE;
      end
      S_TRAP_ILL: illegal_op  = 1'b1;
      S_TRAP_TMO: mem_timeout = 1'b1;
      default:    state_d     = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// tb/tb_imm_alu_sequencer.sv - directed self-checking bench for imm_alu_sequencer
module tb_imm_alu_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       run = 1'b1;
  logic [4:0] ir_opcode = 5'd0;
  logic       mem_ready = 1'b0;
  logic PCOut, MARIn, ZIn, ZLoOut, PCIn, memread, MDRIn, MDROut, IRIn;
  logic Gra, Grb, RIn, ROut, YIn, COut;
  logic [4:0] ALUCode;
  logic busy, instr_done, illegal_op, mem_timeout;

  int vectors = 0;
  int miscompares = 0;

  imm_alu_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir_opcode(ir_opcode), .mem_ready(mem_ready),
    .PCOut(PCOut), .MARIn(MARIn), .ZIn(ZIn), .ZLoOut(ZLoOut), .PCIn(PCIn),
    .memread(memread), .MDRIn(MDRIn), .MDROut(MDROut), .IRIn(IRIn),
    .Gra(Gra), .Grb(Grb), .RIn(RIn), .ROut(ROut), .YIn(YIn), .COut(COut),
    .ALUCode(ALUCode), .busy(busy), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;

  // Strobe order: PCOut MARIn ZIn ZLoOut PCIn memread MDRIn MDROut IRIn Gra Grb RIn ROut YIn COut
  localparam logic [14:0] ST_T0  = 15'h7000;
  localparam logic [14:0] ST_T1W = 15'h0300;
  localparam logic [14:0] ST_T1R = 15'h0F00;
  localparam logic [14:0] ST_T2  = 15'h00C0;
  localparam logic [14:0] ST_T3  = 15'h0016;
  localparam logic [14:0] ST_T4  = 15'h1001;
  localparam logic [14:0] ST_T5  = 15'h0828;

  typedef struct packed {
    logic        chk;
    logic        clr;
    logic        rn;
    logic        rdy;
    logic [4:0]  op;
    logic [23:0] exp;
  } row_t;

  function automatic logic [23:0] pk(logic [14:0] s, logic [4:0] a, logic b, logic d, logic i, logic t);
    return {s, a, b, d, i, t};
  endfunction

  function automatic row_t mk(logic chk, logic clr, logic rn, logic rdy, logic [4:0] op, logic [23:0] exp);
    return '{chk: chk, clr: clr, rn: rn, rdy: rdy, op: op, exp: exp};
  endfunction

  function automatic logic [23:0] obs();
    return {PCOut, MARIn, ZIn, ZLoOut, PCIn, memread, MDRIn, MDROut, IRIn,
            Gra, Grb, RIn, ROut, YIn, COut, ALUCode, busy, instr_done, illegal_op, mem_timeout};
  endfunction

  task automatic apply(input row_t r);
    @(negedge clock);
    clear     = r.clr;
    run       = r.rn;
    mem_ready = r.rdy;
    ir_opcode = r.op;
    #1;
  endtask

  task automatic test_reset();
    row_t v[$];
    v.push_back(mk(1, 0, 1, 1, 5'h0C, '0));
    v.push_back(mk(1, 0, 1, 1, 5'h0C, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 0, 1, 1, 5'h0C, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0C, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL reset cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  task automatic test_addi();
    row_t v[$];
    v.push_back(mk(0, 0, 0, 0, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0C, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0C, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h00, pk(ST_T4, 5'h03, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h00, pk(ST_T5, 5'h00, 1, 1, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h00, '0));
    v.push_back(mk(1, 1, 0, 1, 5'h00, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL addi cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    row_t v[$];
    v.push_back(mk(0, 0, 0, 0, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 0, 5'h0C, '0));
    v.push_back(mk(1, 1, 0, 0, 5'h0C, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    for (int i = 0; i < 3; i++) v.push_back(mk(1, 1, 0, 0, 5'h0C, pk(ST_T1W, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0C, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0C, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0C, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0C, pk(ST_T4, 5'h03, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0C, pk(ST_T5, 5'h00, 1, 1, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0C, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL mem_wait cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t v[$];
    v.push_back(mk(0, 0, 0, 0, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0D, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0D, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0D, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0D, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0D, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0E, pk(ST_T4, 5'h05, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0E, pk(ST_T5, 5'h00, 1, 1, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0D, pk(ST_T4, 5'h06, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0D, pk(ST_T5, 5'h00, 1, 1, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0D, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL back_to_back cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  task automatic test_extra_and_last_wait();
    row_t v[$];
    v.push_back(mk(0, 0, 0, 0, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 0, 5'h0F, '0));
    v.push_back(mk(1, 1, 0, 0, 5'h0F, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    for (int i = 0; i < 14; i++) v.push_back(mk(1, 1, 0, 0, 5'h0F, pk(ST_T1W, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0F, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0F, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0F, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0F, pk(ST_T4, 5'h04, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0F, pk(ST_T5, 5'h00, 1, 1, 0, 0)));
    v.push_back(mk(1, 1, 0, 0, 5'h0F, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL extra_last_wait cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  task automatic test_illegal();
    row_t v[$];
    v.push_back(mk(0, 0, 0, 0, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h00, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h00, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h00, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h00, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(15'h0, 5'h00, 0, 0, 1, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(15'h0, 5'h00, 0, 0, 1, 0)));
    v.push_back(mk(1, 0, 1, 1, 5'h0C, pk(15'h0, 5'h00, 0, 0, 1, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0C, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL illegal cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  task automatic test_timeout();
    row_t v[$];
    v.push_back(mk(0, 0, 0, 0, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 0, 5'h0C, '0));
    v.push_back(mk(1, 1, 1, 0, 5'h0C, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    for (int i = 0; i < 15; i++) v.push_back(mk(1, 1, 1, 0, 5'h0C, pk(ST_T1W, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(15'h0, 5'h00, 0, 0, 0, 1)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(15'h0, 5'h00, 0, 0, 0, 1)));
    v.push_back(mk(1, 0, 1, 1, 5'h0C, pk(15'h0, 5'h00, 0, 0, 0, 1)));
    v.push_back(mk(1, 1, 0, 1, 5'h0C, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL timeout cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  task automatic test_clear_mid_instr();
    row_t v[$];
    v.push_back(mk(0, 0, 0, 0, 5'h00, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0C, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 0, 1, 1, 5'h0C, pk(ST_T4, 5'h03, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 1, 1, 5'h0E, '0));
    v.push_back(mk(1, 1, 1, 1, 5'h0E, pk(ST_T0, 5'h1F, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T1R, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T2, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T3, 5'h00, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T4, 5'h06, 1, 0, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, pk(ST_T5, 5'h00, 1, 1, 0, 0)));
    v.push_back(mk(1, 1, 0, 1, 5'h0E, '0));
    foreach (v[k]) begin
      apply(v[k]);
      if (v[k].chk) begin
        vectors++;
        if (obs() !== v[k].exp) begin
          miscompares++;
          $display("FAIL clear_mid_instr cycle %0d: got %h expected %h", k, obs(), v[k].exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_mem_wait();
    test_back_to_back();
    test_extra_and_last_wait();
    test_illegal();
    test_timeout();
    test_clear_mid_instr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
